// File: rtl/counter_sequencer.sv
// Sequencer for an enable-gated up/down counter: derives the step tick from clk, enforces
// lo/hi bounds in four counting modes and drives the counter's enable, direction and load.
module counter_sequencer #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_en,
    output logic             direction,
    output logic             load,
    output logic [WIDTH-1:0] load_val,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic             cfg_err
);

    localparam int unsigned DivW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

    localparam logic [1:0] ModeWrapUp   = 2'b00;
    localparam logic [1:0] ModeWrapDown = 2'b01;
    localparam logic [1:0] ModePingPong = 2'b10;
    localparam logic [1:0] ModeOneShot  = 2'b11;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic              dir_q, dir_d;
    logic [1:0]        mode_q;
    logic [WIDTH-1:0]  lo_q, hi_q;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;
    logic              tick;
    logic              at_hi, at_lo, bound_hit;

    assign accept = (state_q == StIdle) && start && (lo <= hi);
    assign tick   = (state_q == StRun) && (div_q == DivMax);
    assign at_hi  = (count == hi_q);
    assign at_lo  = (count == lo_q);

    // The bound that ends a run of steps depends on mode and, for ping-pong, on direction.
    always_comb begin
        bound_hit = at_hi;
        case (mode_q)
            ModeWrapUp:   bound_hit = at_hi;
            ModeWrapDown: bound_hit = at_lo;
            ModePingPong: bound_hit = dir_q ? at_hi : at_lo;
            default:      bound_hit = at_hi;
        endcase
    end

    always_comb begin
        state_d = state_q;
        div_d   = '0;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_en  = 1'b0;
        load    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (lo <= hi) begin
                        state_d = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (stop) begin
                    state_d = StIdle;
                end else begin
                    load    = 1'b1;
                    dir_d   = (mode_q != ModeWrapDown);
                    state_d = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else begin
                    div_d = tick ? '0 : div_q + 1'b1;
                    if (tick) begin
                        case (mode_q)
                            ModeWrapUp, ModeWrapDown: begin
                                if (bound_hit) begin
                                    load   = 1'b1;
                                    wrap_d = 1'b1;
                                end else begin
                                    cnt_en = 1'b1;
                                end
                            end
                            ModePingPong: begin
                                // Turning costs one tick: the counter dwells at the bound.
                                if (bound_hit) begin
                                    dir_d  = ~dir_q;
                                    wrap_d = 1'b1;
                                end else begin
                                    cnt_en = 1'b1;
                                end
                            end
                            ModeOneShot: begin
                                if (bound_hit) begin
                                    state_d = StDone;
                                end else begin
                                    cnt_en = 1'b1;
                                end
                            end
                            default: begin
                                cnt_en = 1'b0;
                            end
                        endcase
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Reset must not let a stale state disturb the counter.
        if (rst) begin
            cnt_en = 1'b0;
            load   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            div_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                mode_q <= mode;
                lo_q   <= lo;
                hi_q   <= hi;
            end
        end
    end

    assign load_val  = (mode_q == ModeWrapDown) ? hi_q : lo_q;
    assign busy      = (state_q != StIdle);
    assign direction = dir_q;
    assign wrap      = wrap_q;
    assign done      = done_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a behavioural counter closes the loop, and a cycle model built
// from the bound/tick rules predicts every output; directed scenarios then random traffic.
module tb_counter_sequencer;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned TICK_DIV = 4;

    logic             clk = 1'b0;
    logic             rst, start, stop;
    logic [1:0]       mode;
    logic [WIDTH-1:0] lo, hi;
    logic [WIDTH-1:0] count = '0;
    logic             cnt_en, direction, load, busy, wrap, done, cfg_err;
    logic [WIDTH-1:0] load_val;

    counter_sequencer #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .lo        (lo),
        .hi        (hi),
        .count     (count),
        .cnt_en    (cnt_en),
        .direction (direction),
        .load      (load),
        .load_val  (load_val),
        .busy      (busy),
        .wrap      (wrap),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    // The counter datapath: load beats enable.
    always @(posedge clk) begin
        if (load) count <= load_val;
        else if (cnt_en) count <= direction ? count + 4'd1 : count - 4'd1;
    end

    int total = 0;
    int bad   = 0;
    bit chk   = 1'b0;

    // Model: phase 0 idle, 1 load, 2 run, 3 done; m_cyc counts cycles spent in run.
    int       m_phase = 0;
    int       m_cyc   = 0;
    bit       m_up    = 1'b0;
    bit [1:0] m_mode  = '0;
    bit [3:0] m_lo    = '0;
    bit [3:0] m_hi    = '0;
    bit [3:0] m_cnt   = '0;
    bit       e_wrap  = 1'b0;
    bit       e_done  = 1'b0;
    bit       e_err   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit p, input bit [1:0] md,
                       input bit [3:0] l, input bit [3:0] h);
        bit       tick, hit, e_ld, e_en, n_wrap, n_done, n_err;
        bit [3:0] e_lv;
        rst = r; start = s; stop = p; mode = md; lo = l; hi = h;
        @(negedge clk);
        tick = (m_phase == 2) && ((m_cyc % TICK_DIV) == TICK_DIV - 1);
        case (m_mode)
            2'd0:    hit = (m_cnt == m_hi);
            2'd1:    hit = (m_cnt == m_lo);
            2'd2:    hit = m_up ? (m_cnt == m_hi) : (m_cnt == m_lo);
            default: hit = (m_cnt == m_hi);
        endcase
        e_lv = (m_mode == 2'd1) ? m_hi : m_lo;
        e_ld = 1'b0;
        e_en = 1'b0;
        if (!r && !p) begin
            if (m_phase == 1) e_ld = 1'b1;
            if (m_phase == 2 && tick) begin
                if (m_mode <= 2'd1) begin
                    if (hit) e_ld = 1'b1;
                    else e_en = 1'b1;
                end else if (!hit) begin
                    e_en = 1'b1;
                end
            end
        end
        if (chk) begin
            check("busy", busy, m_phase != 0);
            check("cnt_en", cnt_en, e_en);
            check("load", load, e_ld);
            if (e_ld) check("load_val", load_val, e_lv);
            check("direction", direction, m_up);
            check("wrap", wrap, e_wrap);
            check("done", done, e_done);
            check("cfg_err", cfg_err, e_err);
            check("count", count, m_cnt);
        end
        if (r) begin
            m_phase = 0; m_cyc = 0; m_up = 1'b0;
            m_mode = '0; m_lo = '0; m_hi = '0;
            e_wrap = 1'b0; e_done = 1'b0; e_err = 1'b0;
        end else begin
            n_wrap = 1'b0;
            n_done = (m_phase == 3);
            n_err  = 1'b0;
            case (m_phase)
                0: if (s) begin
                    if (l <= h) begin
                        m_mode = md; m_lo = l; m_hi = h; m_phase = 1;
                    end else begin
                        n_err = 1'b1;
                    end
                end
                1: if (p) m_phase = 0;
                   else begin
                       m_cnt = e_lv; m_up = (m_mode != 2'd1); m_phase = 2; m_cyc = 0;
                   end
                2: if (p) m_phase = 0;
                   else begin
                       if (tick) begin
                           if (e_ld) begin
                               m_cnt = e_lv; n_wrap = 1'b1;
                           end else if (e_en) begin
                               m_cnt = m_up ? 4'(m_cnt + 4'd1) : 4'(m_cnt - 4'd1);
                           end else if (m_mode == 2'd2) begin
                               m_up = !m_up; n_wrap = 1'b1;
                           end else begin
                               m_phase = 3;
                           end
                       end
                       m_cyc++;
                   end
                default: m_phase = 0;
            endcase
            e_wrap = n_wrap; e_done = n_done; e_err = n_err;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    endtask

    initial begin
        bit [3:0] a, b;
        // Bring-up reset; state is unknown until the first edge.
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
        chk = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
        idle(2);

        // Reset mid-run, then a fresh start restarts the divider.
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 4'd3, 4'd5);
        idle(10);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'd3, 4'd5);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 4'd3, 4'd5);
        idle(40);
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 4'd0);

        // Wrap-down, ping-pong, one-shot with start held through done.
        cyc(1'b0, 1'b1, 1'b0, 2'd1, 4'd2, 4'd4);
        idle(30);
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 2'd2, 4'd0, 4'd2);
        idle(40);
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 2'd3, 4'd14, 4'd15);
        idle(4);

        // Rejected config, then stop coinciding with the first tick.
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 4'd9, 4'd3);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 4'd3, 4'd5);
        idle(4);
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 4'd0);
        idle(3);

        // Degenerate lo == hi in every mode.
        for (int m = 0; m < 4; m++) begin
            cyc(1'b0, 1'b1, 1'b0, 2'(m), 4'd7, 4'd7);
            idle(14);
            cyc(1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 4'd0);
        end

        // Random traffic; config inputs wander every cycle to exercise latching.
        for (int i = 0; i < 3000; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) != 0 && a > b) begin
                a = a ^ b; b = a ^ b; a = a ^ b;
            end
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 59) == 0), 2'($urandom_range(0, 3)), a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
